// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler for the real-time clock core.
// Holds NUM_SLOTS programmable HH:MM alarm times, matches them against the
// BCD time of day at the top of each minute, picks the lowest matching slot
// and runs the ring / snooze / timeout sequence.
// Optional feature macro: ALARM_ONESHOT_EN adds a per-slot one-shot bit
// (input wr_oneshot) that disarms a slot when it fires.
module alarm_scheduler #(
   parameter int NUM_SLOTS        = 4,
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZE       = 3,
   localparam int SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic              clk_1s,
   input  logic              reset,
   input  logic [21:0]       cur_time,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [13:0]       wr_hhmm,
   input  logic              wr_enable,
`ifdef ALARM_ONESHOT_EN
   input  logic              wr_oneshot,
`endif
   input  logic              snooze,
   input  logic              stop,
   output logic              alarm,
   output logic [SLOT_W-1:0] active_slot,
   output logic              snoozing,
   output logic [11:0]       snooze_left,
   output logic              missed
);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

   localparam logic [11:0] SNOOZE_LOAD  = 12'(SNOOZE_SEC);
   localparam logic [11:0] TIMEOUT_LAST = 12'(RING_TIMEOUT_SEC - 1);
   localparam logic [3:0]  SNOOZE_MAX   = 4'(MAX_SNOOZE);

   logic [13:0]          slot_hhmm [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_en;
`ifdef ALARM_ONESHOT_EN
   logic [NUM_SLOTS-1:0] slot_oneshot;
`endif

   state_t              state, state_nx;
   logic [11:0]         ring_timer, ring_timer_nx;
   logic [3:0]          snooze_cnt, snooze_cnt_nx;
   logic                alarm_nx, snoozing_nx, missed_nx;
   logic [SLOT_W-1:0]   active_slot_nx;
   logic [11:0]         snooze_left_nx;

   logic                wr_valid;
   logic                active_disable;
   logic                match_any;
   logic [SLOT_W-1:0]   winner;
   logic                fire;

   // Write qualification: out-of-range slot indices are dropped; a write that
   // disables the slot owning the current event aborts that event.
   always_comb begin
      wr_valid       = wr_en && (int'(wr_slot) < NUM_SLOTS);
      active_disable = wr_valid && !wr_enable && (wr_slot == active_slot);
   end

   // Match on pre-write slot contents at second 00; lowest index wins.
   always_comb begin
      match_any = 1'b0;
      winner    = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_en[i] && (slot_hhmm[i] == cur_time[21:8]) && (cur_time[7:0] == 8'h00)) begin
            match_any = 1'b1;
            winner    = SLOT_W'(i);
         end
      end
      fire = (state == IDLE) && match_any;
   end

   // Slot storage; a configuration write overrides a same-edge one-shot disarm.
   always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_hhmm[i] <= '0;
         slot_en <= '0;
`ifdef ALARM_ONESHOT_EN
         slot_oneshot <= '0;
`endif
      end else begin
`ifdef ALARM_ONESHOT_EN
         if (fire && slot_oneshot[winner]) slot_en[winner] <= 1'b0;
`endif
         if (wr_valid) begin
            slot_hhmm[wr_slot] <= wr_hhmm;
            slot_en[wr_slot]   <= wr_enable;
`ifdef ALARM_ONESHOT_EN
            slot_oneshot[wr_slot] <= wr_oneshot;
`endif
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ring_timer  <= '0;
         snooze_cnt  <= '0;
         alarm       <= 1'b0;
         active_slot <= '0;
         snoozing    <= 1'b0;
         snooze_left <= '0;
         missed      <= 1'b0;
      end else begin
         state       <= state_nx;
         ring_timer  <= ring_timer_nx;
         snooze_cnt  <= snooze_cnt_nx;
         alarm       <= alarm_nx;
         active_slot <= active_slot_nx;
         snoozing    <= snoozing_nx;
         snooze_left <= snooze_left_nx;
         missed      <= missed_nx;
      end
   end

   // Next-state and next-output logic; stop outranks snooze, timeout is last.
   always_comb begin
      state_nx       = state;
      ring_timer_nx  = ring_timer;
      snooze_cnt_nx  = snooze_cnt;
      alarm_nx       = alarm;
      active_slot_nx = active_slot;
      snoozing_nx    = snoozing;
      snooze_left_nx = snooze_left;
      missed_nx      = missed;
      case (state)
         IDLE: begin
            if (stop) missed_nx = 1'b0;
            if (match_any) begin
               state_nx       = RING;
               alarm_nx       = 1'b1;
               active_slot_nx = winner;
               ring_timer_nx  = '0;
               snooze_cnt_nx  = '0;
            end
         end
         RING: begin
            if (active_disable || stop) begin
               state_nx = IDLE;
               alarm_nx = 1'b0;
            end else if (snooze && (snooze_cnt < SNOOZE_MAX)) begin
               state_nx       = SNOOZE;
               alarm_nx       = 1'b0;
               snoozing_nx    = 1'b1;
               snooze_left_nx = SNOOZE_LOAD;
               snooze_cnt_nx  = snooze_cnt + 4'd1;
            end else if (ring_timer == TIMEOUT_LAST) begin
               state_nx  = IDLE;
               alarm_nx  = 1'b0;
               missed_nx = 1'b1;
            end else begin
               ring_timer_nx = ring_timer + 12'd1;
            end
         end
         SNOOZE: begin
            if (active_disable || stop) begin
               state_nx       = IDLE;
               snoozing_nx    = 1'b0;
               snooze_left_nx = '0;
            end else if (snooze_left == 12'd1) begin
               state_nx       = RING;
               alarm_nx       = 1'b1;
               ring_timer_nx  = '0;
               snoozing_nx    = 1'b0;
               snooze_left_nx = '0;
            end else begin
               snooze_left_nx = snooze_left - 12'd1;
            end
         end
         default: begin
            state_nx    = IDLE;
            alarm_nx    = 1'b0;
            snoozing_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Testbench for alarm_scheduler: vector table plus hand-written sequences,
// expected outputs queued at drive time and compared one edge later.
module tb_alarm_scheduler;

   logic        clk_1s;
   logic        reset;
   logic [21:0] cur_time;
   logic        wr_en;
   logic [1:0]  wr_slot;
   logic [13:0] wr_hhmm;
   logic        wr_enable;
   logic        wr_oneshot;
   logic        snooze;
   logic        stop;
   logic        alarm;
   logic [1:0]  active_slot;
   logic        snoozing;
   logic [11:0] snooze_left;
   logic        missed;

   alarm_scheduler dut (
      .clk_1s      (clk_1s),
      .reset       (reset),
      .cur_time    (cur_time),
      .wr_en       (wr_en),
      .wr_slot     (wr_slot),
      .wr_hhmm     (wr_hhmm),
      .wr_enable   (wr_enable),
`ifdef ALARM_ONESHOT_EN
      .wr_oneshot  (wr_oneshot),
`endif
      .snooze      (snooze),
      .stop        (stop),
      .alarm       (alarm),
      .active_slot (active_slot),
      .snoozing    (snoozing),
      .snooze_left (snooze_left),
      .missed      (missed)
   );

   initial clk_1s = 1'b0;
   always #5 clk_1s = ~clk_1s;

   typedef struct packed {
      logic        alarm;
      logic [1:0]  slot;
      logic        snoozing;
      logic [11:0] left;
      logic        missed;
   } exp_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  ws;
      logic [13:0] wh;
      logic        wb;
      logic        wo;
      logic [21:0] ct;
      logic        sn;
      logic        sp;
      exp_t        e;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   exp_t  exp_q [$];
   string tag_q [$];
   vec_t  tbl [23];

   function automatic logic [21:0] t(int h, int m, int s);
      return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [13:0] hm(int h, int m);
      logic [21:0] x;
      x = t(h, m, 0);
      return x[21:8];
   endfunction

   function automatic exp_t ex(logic a, logic [1:0] s, logic z, int l, logic m);
      exp_t r;
      r.alarm = a; r.slot = s; r.snoozing = z; r.left = 12'(l); r.missed = m;
      return r;
   endfunction

   function automatic vec_t mkv(logic we, logic [1:0] ws, logic [13:0] wh, logic wb,
                                logic [21:0] ct, logic sn, logic sp, exp_t e);
      vec_t v;
      v.we = we; v.ws = ws; v.wh = wh; v.wb = wb; v.wo = 1'b0;
      v.ct = ct; v.sn = sn; v.sp = sp; v.e = e;
      return v;
   endfunction

   task automatic cmp(input exp_t e, input string tag);
      exp_t act;
      act = {alarm, active_slot, snoozing, snooze_left, missed};
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got alarm=%0b slot=%0d snoozing=%0b left=%0d missed=%0b, want alarm=%0b slot=%0d snoozing=%0b left=%0d missed=%0b",
                  tag, act.alarm, act.slot, act.snoozing, act.left, act.missed,
                  e.alarm, e.slot, e.snoozing, e.left, e.missed);
      end
   endtask

   task automatic pop_check();
      if (exp_q.size() == 0 || tag_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue, want a pending expectation");
      end else begin
         cmp(exp_q.pop_front(), tag_q.pop_front());
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      wr_en = v.we; wr_slot = v.ws; wr_hhmm = v.wh; wr_enable = v.wb; wr_oneshot = v.wo;
      cur_time = v.ct; snooze = v.sn; stop = v.sp;
      exp_q.push_back(v.e);
      tag_q.push_back(tag);
      @(posedge clk_1s);
      #1;
      pop_check();
   endtask

   task automatic run(input logic [21:0] ct, input logic sn, input logic sp,
                      input exp_t e, input string tag);
      apply(mkv(1'b0, 2'd0, 14'd0, 1'b0, ct, sn, sp, e), tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, want finish");
      $fatal(1);
   end

   initial begin
      logic [21:0] nt;
      nt = t(1, 0, 1);
      reset = 1'b1; cur_time = nt; wr_en = 1'b0; wr_slot = '0; wr_hhmm = '0;
      wr_enable = 1'b0; wr_oneshot = 1'b0; snooze = 1'b0; stop = 1'b0;

      tbl[0]  = mkv(1, 2'd1, hm(7, 30), 1, t(7, 29, 59), 0, 0, ex(0, 0, 0, 0, 0));
      tbl[1]  = mkv(1, 2'd0, hm(6, 0),  1, t(7, 29, 59), 0, 0, ex(0, 0, 0, 0, 0));
      tbl[2]  = mkv(1, 2'd2, hm(6, 0),  1, t(7, 29, 59), 0, 0, ex(0, 0, 0, 0, 0));
      tbl[3]  = mkv(0, 2'd0, 14'd0,     0, t(7, 30, 0),  0, 0, ex(1, 1, 0, 0, 0));
      tbl[4]  = mkv(0, 2'd0, 14'd0,     0, t(7, 30, 1),  0, 1, ex(0, 1, 0, 0, 0));
      tbl[5]  = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 0),   0, 0, ex(1, 0, 0, 0, 0));
      tbl[6]  = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 1),   0, 1, ex(0, 0, 0, 0, 0));
      tbl[7]  = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 2),   0, 0, ex(0, 0, 0, 0, 0));
      tbl[8]  = mkv(1, 2'd1, hm(7, 30), 0, t(7, 30, 0),  0, 0, ex(1, 1, 0, 0, 0));
      tbl[9]  = mkv(0, 2'd0, 14'd0,     0, t(7, 30, 1),  0, 1, ex(0, 1, 0, 0, 0));
      tbl[10] = mkv(0, 2'd0, 14'd0,     0, t(7, 30, 0),  0, 0, ex(0, 1, 0, 0, 0));
      tbl[11] = mkv(1, 2'd1, hm(7, 30), 1, nt,           0, 0, ex(0, 1, 0, 0, 0));
      tbl[12] = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 0),   0, 0, ex(1, 0, 0, 0, 0));
      tbl[13] = mkv(1, 2'd0, hm(6, 0),  0, t(6, 0, 1),   0, 0, ex(0, 0, 0, 0, 0));
      tbl[14] = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 0),   0, 0, ex(1, 2, 0, 0, 0));
      tbl[15] = mkv(0, 2'd0, 14'd0,     0, nt,           0, 1, ex(0, 2, 0, 0, 0));
      tbl[16] = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 0),   0, 0, ex(1, 2, 0, 0, 0));
      tbl[17] = mkv(0, 2'd0, 14'd0,     0, t(7, 30, 0),  0, 0, ex(1, 2, 0, 0, 0));
      tbl[18] = mkv(0, 2'd0, 14'd0,     0, nt,           0, 1, ex(0, 2, 0, 0, 0));
      tbl[19] = mkv(0, 2'd0, 14'd0,     0, t(7, 30, 0),  0, 0, ex(1, 1, 0, 0, 0));
      tbl[20] = mkv(1, 2'd2, hm(6, 0),  0, nt,           0, 0, ex(1, 1, 0, 0, 0));
      tbl[21] = mkv(0, 2'd0, 14'd0,     0, nt,           0, 1, ex(0, 1, 0, 0, 0));
      tbl[22] = mkv(0, 2'd0, 14'd0,     0, t(6, 0, 0),   0, 0, ex(0, 1, 0, 0, 0));

      repeat (2) @(posedge clk_1s);
      #1;
      cmp(ex(0, 0, 0, 0, 0), "reset_state");
      @(negedge clk_1s);
      reset = 1'b0;

      for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // snooze three times, fourth request ignored
      run(t(7, 30, 0), 0, 0, ex(1, 1, 0, 0, 0), "snz_ring");
      for (int n = 0; n < 3; n++) begin
         run(t(7, 30, 0), 1, 0, ex(0, 1, 1, 300, 0), "snz_enter");
         for (int k = 1; k < 300; k++)
            run(t(7, 30, 0), 0, 0, ex(0, 1, 1, 300 - k, 0), "snz_count");
         run(nt, 0, 0, ex(1, 1, 0, 0, 0), "snz_expire");
      end
      run(nt, 1, 0, ex(1, 1, 0, 0, 0), "snz_limit");
      run(nt, 1, 0, ex(1, 1, 0, 0, 0), "snz_limit2");
      run(nt, 0, 1, ex(0, 1, 0, 0, 0), "snz_stop");

      // ring timeout: exactly 60 ring cycles then missed
      run(t(7, 30, 0), 0, 0, ex(1, 1, 0, 0, 0), "to_ring");
      for (int k = 1; k < 60; k++) run(nt, 0, 0, ex(1, 1, 0, 0, 0), "to_hold");
      run(nt, 0, 0, ex(0, 1, 0, 0, 1), "to_expire");
      run(nt, 0, 0, ex(0, 1, 0, 0, 1), "missed_sticky");

      // stop beats snooze; stop in ring keeps missed, stop in idle clears it
      run(t(7, 30, 0), 0, 0, ex(1, 1, 0, 0, 1), "ring_missed");
      run(nt, 1, 1, ex(0, 1, 0, 0, 1), "stop_over_snooze");
      run(nt, 0, 1, ex(0, 1, 0, 0, 0), "missed_clear");

      // stop during snooze, then async reset during snooze
      run(t(7, 30, 0), 0, 0, ex(1, 1, 0, 0, 0), "d_ring");
      run(nt, 1, 0, ex(0, 1, 1, 300, 0), "d_snooze");
      run(nt, 0, 0, ex(0, 1, 1, 299, 0), "d_count");
      run(nt, 0, 1, ex(0, 1, 0, 0, 0), "d_stop");
      run(t(7, 30, 0), 0, 0, ex(1, 1, 0, 0, 0), "d_ring2");
      run(nt, 1, 0, ex(0, 1, 1, 300, 0), "d_snooze2");
      #3;
      reset = 1'b1;
      #1;
      cmp(ex(0, 0, 0, 0, 0), "reset_async");
      @(negedge clk_1s);
      @(negedge clk_1s);
      reset = 1'b0;
      run(t(7, 30, 0), 0, 0, ex(0, 0, 0, 0, 0), "reset_slots");

`ifdef ALARM_ONESHOT_EN
      begin
         vec_t v;
         v = mkv(1, 2'd3, hm(12, 0), 1, nt, 0, 0, ex(0, 0, 0, 0, 0));
         v.wo = 1'b1;
         apply(v, "os_write");
      end
      run(t(12, 0, 0), 0, 0, ex(1, 3, 0, 0, 0), "os_fire");
      run(nt, 0, 1, ex(0, 3, 0, 0, 0), "os_stop");
      run(t(12, 0, 0), 0, 0, ex(0, 3, 0, 0, 0), "os_gone");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
